// File: rtl/tftp_field_capture_if.sv
// Record channel from the TFTP field capture block to the file/transfer logic.
// valid/ready: the master holds every rec_* field stable while rec_valid=1 and rec_ready=0; a
// record transfers on any cycle with rec_valid && rec_ready; rec_valid, once raised, never drops without a transfer.
interface tftp_field_capture_if #(
    parameter int FNAME_AW = 5
) ();
    logic                rec_valid;
    logic                rec_ready;
    logic [15:0]         rec_opcode;
    logic [15:0]         rec_blockno;
    logic [FNAME_AW:0]   rec_fname_len;
    logic                rec_mode_octet;
    logic                rec_mode_netascii;
    logic                rec_err;

    modport master (
        output rec_valid, rec_opcode, rec_blockno, rec_fname_len,
               rec_mode_octet, rec_mode_netascii, rec_err,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_opcode, rec_blockno, rec_fname_len,
               rec_mode_octet, rec_mode_netascii, rec_err,
        output rec_ready
    );
endinterface

// File: rtl/tftp_field_capture.sv
// TFTP rx datapath: opcode decode for the decode FSM, field capture under its enables,
// and one completed record per frame on a valid/ready channel.
module tftp_field_capture #(
    parameter int FNAME_MAX = 32,
    parameter int FNAME_AW  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                data_valid,
    input  logic [7:0]          cnt,
    input  logic [7:0]          eth_data,
    input  logic                frame_end,
    input  logic                filename_en,
    input  logic                mode_en,
    output logic                ack,
    output logic                req,
    tftp_field_capture_if.master rec_if,
    input  logic [FNAME_AW-1:0] fname_rd_addr,
    output logic [7:0]          fname_rd_data,
    output logic [7:0]          drop_count
);

    // Per-frame capture state
    logic              r_in_frame;
    logic [15:0]       r_opcode;
    logic [15:0]       r_blockno;
    logic              r_blk_done;
    logic [FNAME_AW:0] r_fname_len;
    logic              r_fname_term;
    logic              r_ovf;
    logic [3:0]        r_mode_idx;
    logic              r_mode_term;
    logic              r_oct_ok;
    logic              r_net_ok;
    logic              r_ack;
    logic              r_req;

    // Record slot
    logic              r_rec_valid;
    logic [15:0]       r_rec_opcode;
    logic [15:0]       r_rec_blockno;
    logic [FNAME_AW:0] r_rec_fname_len;
    logic              r_rec_oct;
    logic              r_rec_net;
    logic              r_rec_err;
    logic [7:0]        r_drop_count;

    logic [7:0]        r_buf [FNAME_MAX];
    logic [7:0]        r_rd_data;

    logic              w_start;
    logic              w_cap;
    logic              w_op_blk;
    logic [15:0]       w_op_now;
    logic              w_fname_full;
    logic              w_blocked;
    logic              w_xfer;
    logic              w_wr;
    logic              w_done;
    logic [7:0]        w_lc;
    logic              w_is_req;
    logic              w_is_blk;
    logic              w_op_bad;
    logic              w_err;

    function automatic logic [7:0] octet_char(input logic [3:0] i);
        case (i)
            4'd0:    octet_char = 8'h6F; // o
            4'd1:    octet_char = 8'h63; // c
            4'd2:    octet_char = 8'h74; // t
            4'd3:    octet_char = 8'h65; // e
            4'd4:    octet_char = 8'h74; // t
            default: octet_char = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] netascii_char(input logic [3:0] i);
        case (i)
            4'd0:    netascii_char = 8'h6E; // n
            4'd1:    netascii_char = 8'h65; // e
            4'd2:    netascii_char = 8'h74; // t
            4'd3:    netascii_char = 8'h61; // a
            4'd4:    netascii_char = 8'h73; // s
            4'd5:    netascii_char = 8'h63; // c
            4'd6:    netascii_char = 8'h69; // i
            4'd7:    netascii_char = 8'h69; // i
            default: netascii_char = 8'h00;
        endcase
    endfunction

    assign w_start      = data_valid && (cnt == 8'h00);
    assign w_cap        = data_valid && r_in_frame && !w_start;
    assign w_op_now     = {r_opcode[15:8], eth_data};
    assign w_op_blk     = (r_opcode == 16'd3) || (r_opcode == 16'd4);
    assign w_fname_full = (r_fname_len == (FNAME_AW+1)'(FNAME_MAX));
    assign w_lc         = ((eth_data >= 8'h41) && (eth_data <= 8'h5A)) ? (eth_data | 8'h20) : eth_data;
    assign w_blocked    = r_rec_valid && !rec_if.rec_ready;
    assign w_xfer       = r_rec_valid && rec_if.rec_ready;
    // A pending record owns the filename buffer, so a blocked frame must not write it.
    assign w_wr         = w_cap && filename_en && !r_fname_term && (eth_data != 8'h00)
                          && !w_fname_full && !w_blocked;
    assign w_done       = frame_end && r_in_frame;

    assign w_is_req = (r_opcode == 16'd1) || (r_opcode == 16'd2);
    assign w_is_blk = w_op_blk;
    assign w_op_bad = (r_opcode == 16'd0) || (r_opcode > 16'd5);
    assign w_err    = w_op_bad || r_ovf
                      || (w_is_req && (!r_fname_term || !r_mode_term
                                       || !((r_oct_ok || r_net_ok) && r_mode_term)))
                      || (w_is_blk && !r_blk_done);

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_in_frame   <= w_start && !reset;
            r_opcode     <= '0;
            r_blockno    <= '0;
            r_blk_done   <= 1'b0;
            r_fname_len  <= '0;
            r_fname_term <= 1'b0;
            r_ovf        <= 1'b0;
            r_mode_idx   <= '0;
            r_mode_term  <= 1'b0;
            r_oct_ok     <= 1'b1;
            r_net_ok     <= 1'b1;
            r_ack        <= 1'b0;
            r_req        <= 1'b0;
        end else begin
            if (frame_end) r_in_frame <= 1'b0;
            if (w_cap) begin
                if (cnt == 8'h2A) r_opcode[15:8] <= eth_data;
                if (cnt == 8'h2B) begin
                    r_opcode[7:0] <= eth_data;
                    r_ack         <= (w_op_now == 16'd4);
                    r_req         <= (w_op_now == 16'd1) || (w_op_now == 16'd2);
                end
                if (cnt == 8'h2C && w_op_blk) r_blockno[15:8] <= eth_data;
                if (cnt == 8'h2D && w_op_blk) begin
                    r_blockno[7:0] <= eth_data;
                    r_blk_done     <= 1'b1;
                end
                if (filename_en && !r_fname_term) begin
                    if (eth_data == 8'h00)  r_fname_term <= 1'b1;
                    else if (w_fname_full)  r_ovf        <= 1'b1;
                    else                    r_fname_len  <= r_fname_len + 1'b1;
                end
                // Both strings are matched in parallel; a match also needs the NUL at exactly its length.
                if (mode_en && !r_mode_term) begin
                    if (eth_data == 8'h00) begin
                        r_mode_term <= 1'b1;
                        r_oct_ok    <= r_oct_ok && (r_mode_idx == 4'd5);
                        r_net_ok    <= r_net_ok && (r_mode_idx == 4'd8);
                    end else begin
                        r_oct_ok <= r_oct_ok && (w_lc == octet_char(r_mode_idx));
                        r_net_ok <= r_net_ok && (w_lc == netascii_char(r_mode_idx));
                        if (r_mode_idx != 4'hF) r_mode_idx <= r_mode_idx + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rec_valid     <= 1'b0;
            r_rec_opcode    <= '0;
            r_rec_blockno   <= '0;
            r_rec_fname_len <= '0;
            r_rec_oct       <= 1'b0;
            r_rec_net       <= 1'b0;
            r_rec_err       <= 1'b0;
            r_drop_count    <= '0;
        end else if (w_done && !w_blocked) begin
            r_rec_valid     <= 1'b1;
            r_rec_opcode    <= r_opcode;
            r_rec_blockno   <= r_blockno;
            r_rec_fname_len <= r_fname_len;
            r_rec_oct       <= r_oct_ok && r_mode_term;
            r_rec_net       <= r_net_ok && r_mode_term;
            r_rec_err       <= w_err;
        end else begin
            if (w_done && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
            if (w_xfer) r_rec_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_buf[r_fname_len[FNAME_AW-1:0]] <= eth_data;
    end

    always_ff @(posedge clk) begin
        if (reset) r_rd_data <= '0;
        else       r_rd_data <= r_buf[fname_rd_addr];
    end

    assign ack                      = r_ack;
    assign req                      = r_req;
    assign rec_if.rec_valid         = r_rec_valid;
    assign rec_if.rec_opcode        = r_rec_opcode;
    assign rec_if.rec_blockno       = r_rec_blockno;
    assign rec_if.rec_fname_len     = r_rec_fname_len;
    assign rec_if.rec_mode_octet    = r_rec_oct;
    assign rec_if.rec_mode_netascii = r_rec_net;
    assign rec_if.rec_err           = r_rec_err;
    assign fname_rd_data            = r_rd_data;
    assign drop_count               = r_drop_count;

endmodule

// File: doc/tftp_field_capture.md
Name: tftp_field_capture

Overview:
- Datapath companion to the TFTP decode state machine in the rx path.
- Decodes the 2-byte opcode from the frame byte stream and returns the ack/req qualifiers the state machine branches on.
- Captures block number, filename and mode under the state machine's field enables, then presents one completed record per frame on a valid/ready interface.
- The downstream file/transfer logic consumes these records.

Parameters:
- FNAME_MAX, 32: filename buffer depth in bytes (power of 2, 4..128).
- FNAME_AW, 5: log2(FNAME_MAX).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- data_valid  in  1  eth_data/cnt valid this cycle
- cnt  in  8  frame byte index (0 = first byte of frame)
- eth_data  in  8  frame byte
- frame_end  in  1  pulse on the cycle after the last byte of a frame
- filename_en  in  1  filename field active (from decode state machine)
- mode_en  in  1  mode field active (from decode state machine)
- ack  out  1  current frame opcode == 4 (ACK)
- req  out  1  current frame opcode == 1 (RRQ) or 2 (WRQ)
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_opcode  out  16  captured opcode
- rec_blockno  out  16  captured block number (0 if not ACK/DATA)
- rec_fname_len  out  FNAME_AW+1  filename length excluding NUL
- rec_mode_octet  out  1  mode string == "octet", case-insensitive
- rec_mode_netascii  out  1  mode string == "netascii", case-insensitive
- rec_err  out  1  record malformed
- fname_rd_addr  in  FNAME_AW  filename buffer read address
- fname_rd_data  out  8  buffer byte, registered, 1-cycle read latency
- drop_count  out  8  saturating count of frames dropped while a record was pending

Behaviour:
- Reset values: all outputs 0; filename buffer contents undefined; per-frame state cleared.
- Byte qualifier: all capture requires data_valid=1. Bytes with data_valid=0 are ignored.
- Frame start (data_valid && cnt==0): clear opcode, blockno, fname_len, mode match flags, the error flag, ack and req.
- Opcode capture: byte at cnt==0x2A gives the opcode high byte; byte at cnt==0x2B gives the low byte.
- ack/req: registered, update on the clock edge that captures the 0x2B byte. They are therefore valid from the cycle in which cnt==0x2C is presented and hold until the next frame start or reset.
- Block number: captured at cnt==0x2C (high) and 0x2D (low) only when the captured opcode is 3 or 4. Otherwise it stays 0.
- Filename (filename_en && data_valid):
  - Non-zero byte: write to buffer[fname_len], increment fname_len.
  - If fname_len==FNAME_MAX: the byte is not written and the overflow error is set.
  - Zero byte: marks the filename terminated.
- Mode (mode_en && data_valid): compare bytes against "octet" and "netascii" in parallel.
  - Fold upper case to lower before comparing.
  - A string matches only if all its characters match and the NUL arrives exactly at its length.
  - Mode terminated on zero byte.
- Record completion on frame_end, when no record is pending:
  - Latch rec_* and set rec_valid=1 on the next edge.
  - rec_err=1 if any of:
    - opcode not in 1..5;
    - filename overflow;
    - opcode 1/2 and (filename not terminated, or mode not terminated, or neither mode flag set);
    - opcode 3/4 and frame ended before cnt 0x2D was captured.
- Handshake:
  - rec_* are stable while rec_valid=1 and rec_ready=0.
  - Transfer occurs on a cycle with rec_valid && rec_ready; rec_valid drops on the next edge.
  - frame_end in the same cycle as the transfer is accepted as the new record; rec_valid stays 1.
- Pending-record rule: while rec_valid=1 (and not being transferred that cycle), an incoming frame makes no buffer writes and no rec_* changes.
  - At that frame's frame_end, drop_count increments, saturating at 255.
  - ack/req still decode for every frame.
- fname_rd_data = buffer[fname_rd_addr], registered.
- Reset mid-frame: all per-frame state, rec_valid and drop_count are cleared. The partial frame produces no record.

Test Plan:
- RRQ frame: opcode 00 01, "file.bin\0", "octet\0", then frame_end -> req=1 and ack=0 from cnt 0x2C; rec_valid=1 with opcode=1, fname_len=8, mode_octet=1, rec_err=0; reading addr 0..7 returns "file.bin".
- ACK frame: opcode 00 04, block 12 34, frame_end -> ack=1; record with opcode=4, blockno=0x1234, fname_len=0, rec_err=0.
- Filename of FNAME_MAX+3 bytes -> fname_len=FNAME_MAX, rec_err=1; no writes beyond the last address.
- Mode "NetASCII\0" -> mode_netascii=1. Mode "octets\0" -> neither flag set, rec_err=1.
- Hold rec_ready=0 across two further frames -> first record unchanged, drop_count=2. Then rec_ready=1 for one cycle -> rec_valid=0.
- Assert reset at cnt 0x30 of a WRQ -> no record, outputs 0. Next clean ACK frame decodes correctly.
